// File: rtl/cache_perf_monitor.sv
// -----------------------------------------------------------------------------
// cache_perf_monitor
//   Performance-counter unit for the pipelined CPU. It counts RUN cycles and
//   NUM_CH independent event channels, for example instruction issued, I-cache
//   stall, jump flush correction and D-memory access.
//   It offers:
//     - start/stop/resume/clear control,
//     - per-channel +1/-1 updates (the -1 is used for flush correction),
//     - a wrap or saturate mode with sticky per-channel overflow flags,
//     - an atomic snapshot bank, read through a registered select port.
//
// Ports
//   clk        in             rising-edge clock
//   rst        in             asynchronous, active-high reset
//   start      in             pulse: begin counting, or resume after a stop
//   stop       in             pulse: freeze counting
//   clear      in             pulse: zero counters, cycle_cnt and ovf; go IDLE
//   snap       in             pulse: copy the post-update counters to shadow
//   ev_inc     in  [NUM_CH]   per-channel +1 request (only acted on in RUN)
//   ev_dec     in  [NUM_CH]   per-channel -1 request (only acted on in RUN)
//   rd_sel     in  [SEL_W]    shadow channel to read
//   rd_data    out [CNT_W]    registered shadow[rd_sel]; 0 if rd_sel >= NUM_CH
//   cycle_cnt  out [CNT_W]    live count of cycles that began in RUN
//   running    out            1 while in RUN
//   ovf        out [NUM_CH]   sticky overflow/underflow flag per channel
// -----------------------------------------------------------------------------
module cache_perf_monitor #(
    parameter int CNT_W    = 32,
    parameter int NUM_CH   = 4,
    parameter int SAT_MODE = 0,
    parameter int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic              snap,
    input  logic [NUM_CH-1:0] ev_inc,
    input  logic [NUM_CH-1:0] ev_dec,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic              running,
    output logic [NUM_CH-1:0] ovf
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FROZEN = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]        state, state_nxt;
    logic              in_run;
    logic [CNT_W-1:0]  cnt       [NUM_CH];
    logic [CNT_W-1:0]  cnt_nxt   [NUM_CH];
    logic [CNT_W-1:0]  shadow    [NUM_CH];
    logic [NUM_CH-1:0] ovf_set;
    logic [NUM_CH-1:0] ovf_nxt;
    logic [CNT_W-1:0]  cycle_nxt;
    logic [CNT_W-1:0]  rd_mux;

    assign in_run  = (state == ST_RUN);
    assign running = in_run;

    // Control FSM. clear beats everything; in RUN, stop beats start.
    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path through the block leaves it unassigned (no inferred latch).
        state_nxt = state;
        if (clear) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (start) state_nxt = ST_RUN;
                ST_RUN:    if (stop)  state_nxt = ST_FROZEN;
                ST_FROZEN: if (start) state_nxt = ST_RUN;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // Channel update. A cycle counts if it begins in RUN, including the cycle
    // in which stop is accepted. When inc and dec arrive together (a flush
    // correction landing on an issue cycle), the channel holds.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_nxt[i] = cnt[i];
            ovf_set[i] = 1'b0;
            if (in_run && ev_inc[i] && !ev_dec[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    ovf_set[i] = 1'b1;
                    cnt_nxt[i] = (SAT_MODE != 0) ? CNT_MAX : '0;
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_ONE;
                end
            end else if (in_run && ev_dec[i] && !ev_inc[i]) begin
                if (cnt[i] == '0) begin
                    ovf_set[i] = 1'b1;
                    cnt_nxt[i] = (SAT_MODE != 0) ? '0 : CNT_MAX;
                end else begin
                    cnt_nxt[i] = cnt[i] - CNT_ONE;
                end
            end
            if (clear) cnt_nxt[i] = '0;
        end
        ovf_nxt = clear ? '0 : (ovf | ovf_set);
    end

    // The cycle counter follows the same wrap/saturate rule, without an
    // overflow flag.
    always_comb begin
        cycle_nxt = cycle_cnt;
        if (clear) begin
            cycle_nxt = '0;
        end else if (in_run) begin
            if ((SAT_MODE != 0) && (cycle_cnt == CNT_MAX)) cycle_nxt = CNT_MAX;
            else                                           cycle_nxt = cycle_cnt + CNT_ONE;
        end
    end

    // The read mux compares against each valid index, so any select value
    // past the last channel falls through to zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == SEL_W'(i)) rd_mux = shadow[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cycle_cnt <= '0;
            ovf       <= '0;
            rd_data   <= '0;
            // NOTE: the shadow bank is a small register array that software
            // may read right after reset, so it is reset like any other
            // register instead of being left to power-up contents.
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]    <= '0;
                shadow[i] <= '0;
            end
        end else begin
            state     <= state_nxt;
            cycle_cnt <= cycle_nxt;
            ovf       <= ovf_nxt;
            rd_data   <= rd_mux;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= cnt_nxt[i];
                // The snapshot takes the post-edge value, so a simultaneous
                // clear captures zero.
                if (snap) shadow[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: doc/cache_perf_monitor.md
# cache_perf_monitor

Parametrised hardware performance-counter unit for the pipelined CPU with direct-mapped I-cache. It counts run cycles plus NUM_CH independent event channels (typically ch0 = instruction issued, ch1 = I-cache stall cycle, ch2 = jump flush correction, ch3 = D-memory access). It supports start/stop/resume/clear control, per-channel increment/decrement for flush correction, a wrap or saturate mode, sticky overflow flags, and an atomic snapshot bank read through a registered select port. It sits beside `top` and lets hit rate and CPI be read from silicon instead of from bench-side counting.

## Interface
- CNT_W, 32, width of every counter, shadow and rd_data
- NUM_CH, 4, number of event channels (≥1)
- SAT_MODE, 0, 0 = modular wrap, 1 = saturate at 0 and 2^CNT_W−1
- SEL_W, $clog2(NUM_CH) (min 1), width of rd_sel
---
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse: begin/resume counting
- stop  in  1  pulse: freeze counting
- clear  in  1  pulse: zero counters, cycle count, ovf; return to IDLE
- snap  in  1  pulse: copy all channel counters into shadow bank
- ev_inc  in  NUM_CH  per-channel +1 request, sampled only in RUN
- ev_dec  in  NUM_CH  per-channel −1 request, sampled only in RUN
- rd_sel  in  SEL_W  shadow channel to read
- rd_data  out  CNT_W  registered shadow[rd_sel]
- cycle_cnt  out  CNT_W  live count of RUN cycles
- running  out  1  1 while in RUN
- ovf  out  NUM_CH  sticky overflow/underflow per channel

## Operation
- States: IDLE, RUN, FROZEN. Reset → IDLE.
- IDLE: start → RUN; stop ignored.
- RUN: stop → FROZEN (stop wins over a simultaneous start).
- FROZEN: start → RUN (resume, counters retained); stop ignored.
- clear, from any state → IDLE; it has priority over start and stop. Counters, cycle_cnt and ovf become 0. The shadow bank is untouched.
- Channel update applies only on a cycle that begins in RUN, including the cycle in which stop is accepted:
  - inc&!dec → +1
  - dec&!inc → −1
  - both or neither → hold
- cycle_cnt +1 on every cycle that begins in RUN. It follows the same wrap/sat rule but has no ovf bit.
- Wrap mode: max+1 → 0, 0−1 → max.
- Sat mode: hold at max or at 0.
- ovf[i] is set by +1 at max or −1 at 0 in either mode. It stays set until clear or rst.
- snap: every shadow[i] takes the value counter[i] holds after the same edge (post-update). With a simultaneous clear, the shadow captures 0.
- rd_data: registered shadow[rd_sel]. If rd_sel ≥ NUM_CH, rd_data is 0.
- Reset values: every counter, shadow, cycle_cnt, rd_data and ovf = 0; running = 0.

## Timing
- Control pulses are sampled at the rising edge.
- running changes on the edge that accepts start or stop.
- An event asserted in cycle k is visible in the counter after edge k (1-cycle latency).
- snap issued at edge k → rd_data reflects it after edge k+1 (2 cycles from snap to rd_data).
- rd_sel change → rd_data valid after the next edge.
- An rst assertion mid-run clears everything immediately (asynchronously), with no wait for clk. The first edge after rst deassertion sees state IDLE.
- Width rules: all arithmetic is CNT_W-bit unsigned, with no carry-out beyond ovf.

## Test plan
- Basic count: rst; start; hold ev_inc=4'b0011 for 10 RUN cycles; stop; snap → ch0 = ch1 = 10, ch2 = ch3 = 0, cycle_cnt = 10, running = 0.
- Flush correction: in RUN, ch0 with inc=1 for 6 cycles, then dec=1 for 2 cycles, then inc and dec both 1 for 3 cycles → ch0 = 4, cycle_cnt = 11.
- Freeze/resume and priority:
  - start; 5 cycles; stop; 7 cycles with events; start; 3 cycles → cycle_cnt = 8, ch0 = 8.
  - start and stop in the same RUN cycle → FROZEN.
  - clear with start in the same cycle → IDLE, all counters 0.
- Wrap vs saturate (CNT_W = 4):
  - SAT_MODE=0: 17 incs → ch0 = 1, ovf[0] = 1.
  - SAT_MODE=1: 17 incs → ch0 = 15, ovf[0] = 1.
  - One dec from 0 → 15 (wrap) or 0 (sat), ovf set in both.
- Snapshot atomicity:
  - Snap at the edge where ch0 goes 9→10 → shadow0 = 10 while the live counter keeps counting.
  - rd_sel = 3 then 1 → rd_data updates one cycle after each change.
  - NUM_CH = 3, rd_sel = 3 → rd_data = 0.
- Async reset mid-run: assert rst between edges while in RUN with nonzero counts → all outputs 0 before the next edge; after release, ev_inc without start does not count.
